serial_sub_nbit: RTL and testbench
==================================

SERIAL_SUB_NBIT -- requirements
Module: serial_sub_nbit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving operand and result width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk_in, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_in, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port start_in, input, 1 bit: request to begin a subtraction; sampled only in IDLE.
REQ-005 The block SHALL have port a_in, input, WIDTH bits: minuend, captured on the accepted start.
REQ-006 The block SHALL have port b_in, input, WIDTH bits: subtrahend, captured on the accepted start.
REQ-007 The block SHALL have port borrow_in, input, 1 bit: initial borrow, captured on the accepted start.
REQ-008 The block SHALL have port busy_out, output, 1 bit: high while in RUN.
REQ-009 The block SHALL have port done_out, output, 1 bit: one-cycle completion pulse.
REQ-010 The block SHALL have port diff_out, output, WIDTH bits: registered result a_in - b_in - borrow_in, modulo 2^WIDTH.
REQ-011 The block SHALL have port borrow_out, output, 1 bit: final borrow out of the MSB.
REQ-012 The block SHALL have port ovf_out, output, 1 bit: two's-complement overflow of the subtraction.

Function
REQ-013 The block SHALL implement states IDLE, RUN and DONE, with a bit counter of ceil(log2(WIDTH+1)) bits.
REQ-014 On an edge in IDLE with start_in=1, it SHALL load a_in, b_in and borrow_in into internal shift and borrow registers, clear the counter and enter RUN.
REQ-015 On each edge in RUN, it SHALL process the operand LSBs a0 and b0 with borrow register br.
REQ-016 Each RUN edge SHALL compute diff bit = a0^b0^br and next br = (~a0&b0) | (~(a0^b0)&br).
REQ-017 Each RUN edge SHALL shift both operand registers right by one and shift the diff bit into the MSB of the internal result register.
REQ-018 After exactly WIDTH RUN edges, it SHALL enter DONE; diff_out, borrow_out and ovf_out SHALL update on that same edge.
REQ-019 ovf_out SHALL equal (a[W-1] != b[W-1]) && (diff[W-1] != a[W-1]), using the operands as captured.
REQ-020 In DONE, done_out SHALL be 1 for exactly one cycle; the next edge SHALL return to IDLE unconditionally.
REQ-021 Latency SHALL be WIDTH+1 clocks from the start-accepting edge to the edge after which done_out is first high.
REQ-022 diff_out, borrow_out and ovf_out SHALL hold their values until the next completion or reset, not changing during a later RUN.
REQ-023 start_in SHALL be ignored in RUN and DONE, with no queuing.
REQ-024 If start_in is held high continuously, a new operation SHALL be accepted in the IDLE cycle immediately after DONE, giving one operation per WIDTH+2 clocks.
REQ-025 a_in, b_in and borrow_in changing after acceptance SHALL NOT affect the result in progress.

Reset
REQ-026 When rst_in=1 at an edge, the block SHALL go to IDLE and clear busy_out, done_out, diff_out, borrow_out, ovf_out, the counter and all internal registers to 0; reset SHALL take priority over start_in and over any state.
REQ-027 Reset asserted mid-RUN SHALL abort the operation with no done_out pulse; the first start after reset deasserts SHALL be accepted normally.

Verification
REQ-028 Bench SHALL apply WIDTH=8, a=0x05, b=0x03, bin=0 -> diff_out=0x02, borrow_out=0, ovf_out=0, with done_out pulsed 9 clocks after acceptance.
REQ-029 Bench SHALL apply a=0x03, b=0x05, bin=0 -> diff_out=0xFE, borrow_out=1, ovf_out=0.
REQ-030 Bench SHALL apply a=0x00, b=0x00, bin=1 -> diff_out=0xFF, borrow_out=1, ovf_out=0.
REQ-031 Bench SHALL apply a=0x80, b=0x01, bin=0 -> diff_out=0x7F, borrow_out=0, ovf_out=1.
REQ-032 Bench SHALL pulse start_in with new operands during RUN -> ignored, and the original result is produced.
REQ-033 Bench SHALL hold start_in high continuously -> operations are accepted back-to-back every 10 clocks with WIDTH=8.
REQ-034 Bench SHALL assert rst_in at RUN bit 4 -> all outputs 0 and no done_out pulse; a subsequent start of a=0x10, b=0x01 -> diff_out=0x0F.
REQ-035 Bench SHALL check every case against a reference {borrow,diff} = a - b - bin computed at WIDTH+1 bits.

Source files
------------

// File: rtl/serial_sub_nbit.sv
// Bit-serial WIDTH-bit subtractor: a - b - borrow_in, one bit per clock LSB first.
// Result, final borrow and signed overflow are registered on the last RUN edge and held.
module serial_sub_nbit #(
    parameter int WIDTH = 8
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             start_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             borrow_in,
    output logic             busy_out,
    output logic             done_out,
    output logic [WIDTH-1:0] diff_out,
    output logic             borrow_out,
    output logic             ovf_out
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0] a_sh, b_sh, res;
    logic             br;
    logic             a_msb, b_msb;
    logic [CNT_W-1:0] cnt;

    logic d_bit, br_next, last_bit;

    function automatic logic full_sub_borrow(input logic a, input logic b, input logic bi);
        return (~a & b) | (~(a ^ b) & bi);
    endfunction

    always_comb begin
        d_bit    = a_sh[0] ^ b_sh[0] ^ br;
        br_next  = full_sub_borrow(a_sh[0], b_sh[0], br);
        last_bit = (cnt == CNT_W'(WIDTH - 1));
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        busy_out   = 1'b0;
        done_out   = 1'b0;
        case (state)
            IDLE: if (start_in) state_next = RUN;
            RUN: begin
                busy_out = 1'b1;
                if (last_bit) state_next = DONE;
            end
            DONE: begin
                done_out   = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand capture, serial bit step, and result commit on the final bit
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            a_sh       <= '0;
            b_sh       <= '0;
            res        <= '0;
            br         <= 1'b0;
            a_msb      <= 1'b0;
            b_msb      <= 1'b0;
            cnt        <= '0;
            diff_out   <= '0;
            borrow_out <= 1'b0;
            ovf_out    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_in) begin
                        a_sh  <= a_in;
                        b_sh  <= b_in;
                        br    <= borrow_in;
                        a_msb <= a_in[WIDTH-1];
                        b_msb <= b_in[WIDTH-1];
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    a_sh <= {1'b0, a_sh[WIDTH-1:1]};
                    b_sh <= {1'b0, b_sh[WIDTH-1:1]};
                    res  <= {d_bit, res[WIDTH-1:1]};
                    br   <= br_next;
                    cnt  <= cnt + 1'b1;
                    // d_bit is the result MSB on the last edge
                    if (last_bit) begin
                        diff_out   <= {d_bit, res[WIDTH-1:1]};
                        borrow_out <= br_next;
                        ovf_out    <= (a_msb != b_msb) && (d_bit != a_msb);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sub_nbit.sv
// Self-checking bench for serial_sub_nbit (WIDTH=8): directed table, corner sequences,
// and randomized operations against an integer-arithmetic reference model.
module tb_serial_sub_nbit;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a, b;
    logic         bin;
    logic         busy, done;
    logic [W-1:0] diff;
    logic         bout, ovf;

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] prev_exp;

    serial_sub_nbit #(.WIDTH(W)) dut (
        .clk_in    (clk),
        .rst_in    (rst),
        .start_in  (start),
        .a_in      (a),
        .b_in      (b),
        .borrow_in (bin),
        .busy_out  (busy),
        .done_out  (done),
        .diff_out  (diff),
        .borrow_out(bout),
        .ovf_out   (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         bin;
        logic [W-1:0] diff;
        logic         bout;
        logic         ovf;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic, unsigned for diff/borrow, signed range for overflow
    task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mbin,
                         output logic [W-1:0] md, output logic mbo, output logic mov);
        int u, s;
        u   = int'(ma) - int'(mb) - int'(mbin);
        s   = int'($signed(ma)) - int'($signed(mb)) - int'(mbin);
        md  = u[W-1:0];
        mbo = (u < 0);
        mov = (s > 127) || (s < -128);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One operation from IDLE; operands are scrambled after acceptance. Returns edges
    // counted inclusively from the accepting edge to the edge after which done is high.
    task automatic do_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic obin,
                         output int lat);
        logic stable;
        stable = 1'b1;
        start = 1'b1; a = oa; b = ob; bin = obin;
        step();
        start = 1'b0;
        a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
        chk("busy_after_accept", {31'd0, busy}, 32'd1);
        lat = 1;
        while (!done && lat < 40) begin
            if (busy && diff !== prev_exp) stable = 1'b0;
            step();
            lat++;
        end
        chk("result_held_during_run", {31'd0, stable}, 32'd1);
        if (lat >= 40) chk("done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int lat;
        int cnt_done;
        int done_at[$];
        logic [W-1:0] ed;
        logic eb, eo;
        logic [W-1:0] ra, rb;
        logic rbin;

        vecs[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0};
        vecs[1] = '{8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0};
        vecs[2] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[3] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
        vecs[4] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
        vecs[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};

        rst = 1'b1; start = 1'b1; a = 8'hAA; b = 8'h55; bin = 1'b1;
        step(); step();
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_diff", {24'd0, diff}, 32'd0);
        chk("rst_borrow", {31'd0, bout}, 32'd0);
        chk("rst_ovf", {31'd0, ovf}, 32'd0);
        rst = 1'b0; start = 1'b0;
        step();
        prev_exp = '0;

        for (int i = 0; i < 6; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].bin, lat);
            model(vecs[i].a, vecs[i].b, vecs[i].bin, ed, eb, eo);
            chk("tbl_latency", lat, W + 1);
            chk("tbl_diff", {24'd0, diff}, {24'd0, vecs[i].diff});
            chk("tbl_borrow", {31'd0, bout}, {31'd0, vecs[i].bout});
            chk("tbl_ovf", {31'd0, ovf}, {31'd0, vecs[i].ovf});
            chk("tbl_model", {22'd0, bout, ovf, diff}, {22'd0, eb, eo, ed});
            step();
            chk("tbl_done_one_cycle", {31'd0, done}, 32'd0);
            prev_exp = vecs[i].diff;
        end

        // start pulsed with new operands mid-RUN must be ignored
        start = 1'b1; a = 8'h40; b = 8'h15; bin = 1'b0;
        step();
        start = 1'b0;
        step(); step(); step();
        start = 1'b1; a = 8'h01; b = 8'h02; bin = 1'b1;
        step();
        start = 1'b0;
        lat = 0;
        while (!done && lat < 40) begin step(); lat++; end
        chk("ign_diff", {24'd0, diff}, 32'h2B);
        chk("ign_borrow", {31'd0, bout}, 32'd0);
        chk("ign_ovf", {31'd0, ovf}, 32'd0);
        step(); step(); step();
        chk("ign_no_queued_op", {31'd0, busy}, 32'd0);
        prev_exp = 8'h2B;

        // start held high: one operation per W+2 clocks
        start = 1'b1; a = 8'h22; b = 8'h11; bin = 1'b0;
        for (int c = 0; c < 35; c++) begin
            step();
            if (done) done_at.push_back(c);
        end
        start = 1'b0;
        chk("b2b_count", done_at.size(), 3);
        if (done_at.size() == 3) begin
            chk("b2b_first", done_at[0], W);
            chk("b2b_period1", done_at[1] - done_at[0], W + 2);
            chk("b2b_period2", done_at[2] - done_at[1], W + 2);
        end
        chk("b2b_diff", {24'd0, diff}, 32'h11);
        for (int c = 0; c < 12; c++) step();
        prev_exp = 8'h11;

        // reset during RUN bit 4 aborts with no done pulse
        start = 1'b1; a = 8'h9C; b = 8'h37; bin = 1'b1;
        step();
        start = 1'b0;
        step(); step(); step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_diff", {24'd0, diff}, 32'd0);
        chk("abort_borrow", {31'd0, bout}, 32'd0);
        chk("abort_ovf", {31'd0, ovf}, 32'd0);
        cnt_done = 0;
        for (int c = 0; c < 12; c++) begin
            step();
            if (done) cnt_done++;
        end
        chk("abort_no_done", cnt_done, 0);
        prev_exp = '0;
        do_op(8'h10, 8'h01, 1'b0, lat);
        chk("post_rst_latency", lat, W + 1);
        chk("post_rst_diff", {24'd0, diff}, 32'h0F);
        chk("post_rst_borrow", {31'd0, bout}, 32'd0);
        step();
        prev_exp = 8'h0F;

        for (int i = 0; i < 30; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rbin = 1'($urandom);
            if (i == 0) begin ra = 8'h80; rb = 8'h00; rbin = 1'b1; end
            do_op(ra, rb, rbin, lat);
            model(ra, rb, rbin, ed, eb, eo);
            chk("rnd_latency", lat, W + 1);
            chk("rnd_diff", {24'd0, diff}, {24'd0, ed});
            chk("rnd_borrow", {31'd0, bout}, {31'd0, eb});
            chk("rnd_ovf", {31'd0, ovf}, {31'd0, eo});
            step();
            prev_exp = ed;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
